// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB-first, optional even parity, stop period.
// Each bit is timed by s_tick strobes. Defining UART_TX_PARITY_EN adds a parity bit after the data bits.
module uart_tx #(
    parameter int DBIT    = 8,
    parameter int OVS     = 16,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            tx_start,
    input  logic [DBIT-1:0] i_data,
    output logic            o_tx,
    output logic            o_tx_done_tick,
    output logic            o_tx_busy
);

    localparam int CNT_MAX = (OVS > SB_TICK) ? OVS : SB_TICK;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int BW      = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [CW-1:0] OVS_LAST  = CW'(OVS - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(SB_TICK - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DBIT - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd4;
`endif

    logic [2:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [DBIT-1:0] shift_q, shift_d;
    logic            tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic            parity_q, parity_d;
`endif

    always_comb begin
        // NOTE: every signal gets a default up front so no path through the case infers a latch.
        state_d        = state_q;
        cnt_d          = cnt_q;
        bit_d          = bit_q;
        shift_d        = shift_q;
        tx_d           = tx_q;
        o_tx_done_tick = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d       = parity_q;
`endif
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (tx_start) begin
                    shift_d = i_data;
                    cnt_d   = '0;
                    state_d = START;
                    tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^i_data;
`endif
                end
            end
            START: begin
                if (s_tick) begin
                    if (cnt_q == OVS_LAST) begin
                        cnt_d   = '0;
                        bit_d   = '0;
                        state_d = DATA;
                        tx_d    = shift_q[0];
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (cnt_q == OVS_LAST) begin
                        cnt_d   = '0;
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 1'b1;
                        tx_d    = shift_d[0];
                        if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state_d = PARITY;
                            tx_d    = parity_q;
`else
                            state_d = STOP;
                            tx_d    = 1'b1;
`endif
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (cnt_q == OVS_LAST) begin
                        cnt_d   = '0;
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (cnt_q == STOP_LAST) begin
                        cnt_d          = '0;
                        state_d        = IDLE;
                        tx_d           = 1'b1;
                        o_tx_done_tick = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // The line is driven from tx_q, which is loaded with the next bit value, so o_tx never glitches.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign o_tx      = tx_q;
    assign o_tx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed frames with a line-level scoreboard sampled mid-bit.
// Also covers reset behaviour, back-to-back frames, ignored requests and parity (UART_TX_PARITY_EN).
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int DBIT    = 8;
    localparam int OVS     = 16;
    localparam int SB_TICK = 16;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME_TICKS = (1 + PAR + DBIT) * OVS + SB_TICK;
    localparam int BUDGET      = 1000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s_tick = 1'b0;
    logic       req = 1'b0;
    logic       drop_mode = 1'b0;
    logic       tx_start;
    logic [7:0] i_data = 8'h00;
    logic       o_tx, o_tx_done_tick, o_tx_busy;

    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;
    int   k = 0;
    int   base = 0;
    logic busy_prev = 1'b0;
    logic exp_q[$];

    // The requester drops its request combinationally on the done pulse when drop_mode is set.
    assign tx_start = req & ~(drop_mode & o_tx_done_tick);

    uart_tx #(.DBIT(DBIT), .OVS(OVS), .SB_TICK(SB_TICK)) dut (
        .clk            (clk),
        .reset          (reset),
        .s_tick         (s_tick),
        .tx_start       (tx_start),
        .i_data         (i_data),
        .o_tx           (o_tx),
        .o_tx_done_tick (o_tx_done_tick),
        .o_tx_busy      (o_tx_busy)
    );

    always #5 clk = ~clk;

    initial begin : tick_gen
        int div;
        div = 0;
        forever begin
            @(posedge clk);
            #2;
            s_tick = (div == 3);
            div    = (div + 1) % 4;
        end
    end

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Line monitor: counts frame ticks, pops one expected level at the middle of every bit.
    initial begin : monitor
        logic lvl;
        forever begin
            @(negedge clk);
            if (o_tx_busy && !busy_prev) k = 0;
            if (o_tx_busy && s_tick) begin
                k++;
                if (k % OVS == OVS / 2) begin
                    check_bit("sb_nonempty", exp_q.size() > 0, 1'b1);
                    if (exp_q.size() > 0) begin
                        lvl = exp_q.pop_front();
                        check_bit("line_mid_bit", o_tx, lvl);
                    end
                end
            end
            if (o_tx_done_tick) begin
                done_cnt++;
                check_int("frame_ticks", k, FRAME_TICKS);
            end
            busy_prev = o_tx_busy;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [7:0] d);
        exp_q.push_back(1'b0);
        for (int i = 0; i < DBIT; i++) exp_q.push_back(d[i]);
        if (PAR == 1) exp_q.push_back(^d);
        exp_q.push_back(1'b1);
    endtask

    task automatic send(input logic [7:0] d);
        push_frame(d);
        step();
        i_data = d;
        req    = 1'b1;
        step();
        req    = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        int start;
        n     = 0;
        start = done_cnt;
        while (done_cnt == start && n < BUDGET) begin
            sample();
            n++;
        end
        check_bit("done_within_budget", done_cnt != start, 1'b1);
        if (drop_mode) req = 1'b0;
    endtask

    task automatic idle_checks(input int exp_done);
        repeat (40) step();
        sample();
        check_int("done_count", done_cnt, exp_done);
        check_bit("idle_busy", o_tx_busy, 1'b0);
        check_bit("idle_line", o_tx, 1'b1);
        check_int("sb_drained", exp_q.size(), 0);
    endtask

    initial begin
        repeat (3) step();
        sample();
        check_bit("rst_line", o_tx, 1'b1);
        check_bit("rst_busy", o_tx_busy, 1'b0);
        check_bit("rst_done", o_tx_done_tick, 1'b0);
        step();
        reset = 1'b0;
        repeat (5) step();

        // Reset while idle
        reset = 1'b1;
        sample();
        check_bit("idle_rst_line", o_tx, 1'b1);
        check_bit("idle_rst_busy", o_tx_busy, 1'b0);
        check_bit("idle_rst_done", o_tx_done_tick, 1'b0);
        step();
        reset = 1'b0;
        repeat (3) step();

        // Single 0x55 frame from a one-cycle request
        base = done_cnt;
        send(8'h55);
        sample();
        check_bit("accept_line_low", o_tx, 1'b0);
        check_bit("accept_busy", o_tx_busy, 1'b1);
        wait_done();
        step();
        sample();
        check_bit("busy_falls_after_done", o_tx_busy, 1'b0);
        idle_checks(base + 1);

        // Request held, dropped combinationally on done
        base      = done_cnt;
        drop_mode = 1'b1;
        push_frame(8'hA3);
        i_data = 8'hA3;
        req    = 1'b1;
        wait_done();
        step();
        sample();
        check_bit("held_busy_falls", o_tx_busy, 1'b0);
        drop_mode = 1'b0;
        idle_checks(base + 1);

        // Request held across done: back-to-back 0x01 then 0xFE
        base = done_cnt;
        push_frame(8'h01);
        push_frame(8'hFE);
        i_data = 8'h01;
        req    = 1'b1;
        repeat (40) step();
        i_data = 8'hFE;
        wait_done();
        step();
        sample();
        check_bit("b2b_gap_busy", o_tx_busy, 1'b0);
        check_bit("b2b_gap_line", o_tx, 1'b1);
        step();
        sample();
        check_bit("b2b_restart_busy", o_tx_busy, 1'b1);
        check_bit("b2b_restart_line", o_tx, 1'b0);
        req = 1'b0;
        wait_done();
        idle_checks(base + 2);

        // Requests and data changes during DATA are ignored
        base = done_cnt;
        send(8'h3C);
        repeat (100) step();
        repeat (3) begin
            req    = 1'b1;
            i_data = ~i_data;
            step();
            req = 1'b0;
            repeat (37) step();
        end
        wait_done();
        idle_checks(base + 1);

        // Reset in the middle of DATA drops the frame
        base = done_cnt;
        send(8'h00);
        repeat (160) step();
        sample();
        check_bit("pre_reset_line", o_tx, 1'b0);
        check_bit("pre_reset_busy", o_tx_busy, 1'b1);
        step();
        reset = 1'b1;
        sample();
        check_bit("mid_rst_line", o_tx, 1'b1);
        check_bit("mid_rst_busy", o_tx_busy, 1'b0);
        check_bit("mid_rst_done", o_tx_done_tick, 1'b0);
        step();
        reset = 1'b0;
        exp_q.delete();
        repeat (900) step();
        idle_checks(base);

        // Parity-relevant words (odd and even popcount)
        base = done_cnt;
        send(8'h07);
        wait_done();
        step();
        send(8'h03);
        wait_done();
        idle_checks(base + 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
